// File: rtl/load_store_unit.sv
// load_store_unit: data-memory stage between decode and writeback.
// Accepts one word-aligned load or store, drives the data memory strobes
// until mem_ready, returns load data as a one-cycle pulse and reports
// misalignment or access timeout on err_code.
// Optional feature macro: LSU_TIMEOUT_EN. When it is defined, a cycle
// counter aborts accesses that never see mem_ready. When it is undefined,
// ACCESS waits forever and err_code is only 00 or 01.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clk_en,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dest,
  output logic        busy,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [2:0]  resp_dest,
  output logic [1:0]  err_code
);

  // The timeout check must fire before the counter wraps.
  localparam bit PARAMS_OK = (TIMEOUT_CYCLES >= 2) && ((64'd1 << CNT_W) > 64'(TIMEOUT_CYCLES));

  if (!PARAMS_OK) begin : g_bad_params
    $error("load_store_unit: need TIMEOUT_CYCLES >= 2 and 2**CNT_W > TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  dest_q, dest_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [2:0]  resp_dest_q, resp_dest_d;
  logic [1:0]  err_code_q, err_code_d;
`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    mem_a_d      = mem_a_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    dest_d       = dest_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_dest_d  = resp_dest_q;
    err_code_d   = err_code_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00) begin
            state_d    = ERROR;
            err_code_d = 2'b01;
          end else begin
            state_d     = ACCESS;
            mem_a_d     = req_addr;
            mem_wdata_d = req_store ? req_wdata : 32'd0;
            mem_read_d  = ~req_store;
            mem_write_d = req_store;
            dest_d      = req_dest;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          mem_a_d     = 32'd0;
          mem_wdata_d = 32'd0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            resp_valid_d = 1'b1;
            resp_data_d  = mem_rdata;
            resp_dest_d  = dest_q;
            state_d      = RESP;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_a_d     = 32'd0;
          mem_wdata_d = 32'd0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_code_d  = 2'b10;
          state_d     = ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; clk_en low freezes everything.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      mem_a_q      <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      dest_q       <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_dest_q  <= 3'd0;
      err_code_q   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else if (clk_en) begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      mem_a_q      <= mem_a_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      dest_q       <= dest_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_dest_q  <= resp_dest_d;
      err_code_q   <= err_code_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign mem_a      = mem_a_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_dest  = resp_dest_q;
  assign err_code   = err_code_q;

endmodule
